// File: rtl/lcd_timing_gen.sv
// Raster timing generator for a 480x272 LCD on the 9 MHz pixel clock: syncs, data-enable,
// pixel/line counters and frame-start pulse. Optional frameCount output under LCD_FRAME_COUNT_EN.
module lcd_timing_gen #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_SYNC   = 10,
    parameter int unsigned V_BP     = 2
) (
    input  logic        clk9MHz,
    input  logic        reset_n,
    input  logic        enable,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        dataEnable,
    output logic [9:0]  vgaCount,
    output logic [8:0]  lineCount,
    output logic        start,
    output logic        frameStart
`ifdef LCD_FRAME_COUNT_EN
    ,
    output logic [15:0] frameCount
`endif
);

    localparam int unsigned H_W     = 10;
    localparam int unsigned V_W     = 9;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_END   = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SYNC_BEG  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_SYNC_LAST = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] V_LAST      = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT_END   = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SYNC_BEG  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_SYNC_LAST = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic           hsync_n_q, hsync_n_d;
    logic           vsync_n_q, vsync_n_d;
    logic           de_q, de_d;
    logic           frame_start_q, frame_start_d;
    logic           line_end;
    logic           frame_end;
    logic           running_d;

    // Next state and next counts; outputs are derived from the next counts so that
    // registered syncs/enables line up with the registered counters in the same cycle.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        line_end  = (h_q == H_LAST);
        frame_end = line_end && (v_q == V_LAST);

        case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (line_end) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
                end else begin
                    h_d = h_q + H_W'(1);
                end
                // A draining frame only stops at its final wrap; re-enable resumes seamlessly.
                if (enable) begin
                    state_d = ST_RUN;
                end else if ((state_q == ST_DRAIN) && frame_end) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase

        running_d     = (state_d != ST_IDLE);
        de_d          = running_d && (h_d < H_ACT_END) && (v_d < V_ACT_END);
        hsync_n_d     = !(running_d && (h_d >= H_SYNC_BEG) && (h_d <= H_SYNC_LAST));
        vsync_n_d     = !(running_d && (v_d >= V_SYNC_BEG) && (v_d <= V_SYNC_LAST));
        frame_start_d = running_d && (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge clk9MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            h_q           <= '0;
            v_q           <= '0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vgaCount   = h_q;
    assign lineCount  = v_q;
    assign hsync_n    = hsync_n_q;
    assign vsync_n    = vsync_n_q;
    assign dataEnable = de_q;
    assign start      = de_q;
    assign frameStart = frame_start_q;

`ifdef LCD_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Counts in step with the frameStart pulse, so the new value is visible during it.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk9MHz or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frameCount = frame_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: full-size instance for line/start/reset timing, a shrunken
// instance for whole-frame, drain and randomized enable checks against a frame-position model.
module tb_lcd_timing_gen;

    localparam int S_HA = 16, S_HF = 2, S_HS = 5, S_HB = 3;
    localparam int S_VA = 8,  S_VF = 2, S_VS = 3, S_VB = 2;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FT = S_HT * S_VT;
    localparam logic [23:0] IDLE_VEC = 24'hC00000;

    logic clk;
    logic rst_n;
    logic en_full, en_small;

    logic       f_hs, f_vs, f_de, f_st, f_fs;
    logic [9:0] f_vga;
    logic [8:0] f_line;
    logic       s_hs, s_vs, s_de, s_st, s_fs;
    logic [9:0] s_vga;
    logic [8:0] s_line;
    logic [23:0] f_vec, s_vec;
`ifdef LCD_FRAME_COUNT_EN
    logic [15:0] f_fc, s_fc;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model of the small instance: position within the frame plus run status.
    logic        m_active;
    int          m_pos;
    logic        m_last_en;
    logic [15:0] m_fc;

    assign f_vec = {f_hs, f_vs, f_de, f_st, f_fs, f_vga, f_line};
    assign s_vec = {s_hs, s_vs, s_de, s_st, s_fs, s_vga, s_line};

    lcd_timing_gen u_full (
        .clk9MHz    (clk),
        .reset_n    (rst_n),
        .enable     (en_full),
        .hsync_n    (f_hs),
        .vsync_n    (f_vs),
        .dataEnable (f_de),
        .vgaCount   (f_vga),
        .lineCount  (f_line),
        .start      (f_st),
        .frameStart (f_fs)
`ifdef LCD_FRAME_COUNT_EN
        ,
        .frameCount (f_fc)
`endif
    );

    lcd_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_small (
        .clk9MHz    (clk),
        .reset_n    (rst_n),
        .enable     (en_small),
        .hsync_n    (s_hs),
        .vsync_n    (s_vs),
        .dataEnable (s_de),
        .vgaCount   (s_vga),
        .lineCount  (s_line),
        .start      (s_st),
        .frameStart (s_fs)
`ifdef LCD_FRAME_COUNT_EN
        ,
        .frameCount (s_fc)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_active  = 1'b0;
        m_pos     = 0;
        m_last_en = 1'b0;
        m_fc      = '0;
    endtask

    // A frame ends only at its last position with enable low on this and the previous sample.
    task automatic model_step(input logic en);
        if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else if (m_pos == S_FT - 1 && !en && !m_last_en) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else begin
            m_pos = (m_pos + 1) % S_FT;
        end
        m_last_en = en;
        if (m_active && m_pos == 0) m_fc = m_fc + 16'd1;
    endtask

    function automatic logic [23:0] model_vec();
        int x, y;
        logic hs, vs, de, fs;
        if (!m_active) return IDLE_VEC;
        x  = m_pos % S_HT;
        y  = m_pos / S_HT;
        hs = !(x >= S_HA + S_HF && x < S_HA + S_HF + S_HS);
        vs = !(y >= S_VA + S_VF && y < S_VA + S_VF + S_VS);
        de = (x < S_HA) && (y < S_VA);
        fs = (m_pos == 0);
        return {hs, vs, de, de, fs, 10'(x), 9'(y)};
    endfunction

    task automatic step_full();
        @(posedge clk);
        model_step(en_small);
        #1;
    endtask

    task automatic step_small(input logic en);
        en_small = en;
        @(posedge clk);
        model_step(en);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (f_vec !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_full: got %h expected %h", f_vec, IDLE_VEC);
        end
        checks++;
        if (s_vec !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_small: got %h expected %h", s_vec, IDLE_VEC);
        end
`ifdef LCD_FRAME_COUNT_EN
        checks++;
        if (f_fc !== 16'd0) begin
            errors++;
            $display("FAIL reset_framecount: got %0d expected 0", f_fc);
        end
`endif
        rst_n = 1'b1;
        step_full();
        checks++;
        if (f_vec !== IDLE_VEC) begin
            errors++;
            $display("FAIL idle_hold: got %h expected %h", f_vec, IDLE_VEC);
        end
    endtask

    task automatic test_first_pixel();
        en_full = 1'b1;
        step_full();
        checks++;
        if ({f_fs, f_st, f_de, f_hs, f_vs, f_vga, f_line} !== {5'b11111, 10'd0, 9'd0}) begin
            errors++;
            $display("FAIL first_pixel: got fs=%b st=%b de=%b hs=%b vs=%b x=%0d y=%0d expected 1 1 1 1 1 0 0",
                     f_fs, f_st, f_de, f_hs, f_vs, f_vga, f_line);
        end
        step_full();
        checks++;
        if ({f_fs, f_st, f_vga} !== {2'b01, 10'd1}) begin
            errors++;
            $display("FAIL second_pixel: got fs=%b st=%b x=%0d expected 0 1 1", f_fs, f_st, f_vga);
        end
    endtask

    task automatic test_line();
        int st_hi = 0, skew = 0, hs_lo = 0, hs_first = -1, hs_last = -1;
        int wraps = 0, wrap_k = -1, wrap_line = -1, fs_cnt = 0;
        for (int k = 1; k <= 525; k++) begin
            step_full();
            if (f_st) st_hi++;
            if (f_de !== f_st) skew++;
            if (f_fs) fs_cnt++;
            if (!f_hs) begin
                hs_lo++;
                if (hs_first < 0) hs_first = int'(f_vga);
                hs_last = int'(f_vga);
            end
            if (f_vga == 10'd0) begin
                wraps++;
                wrap_k    = k;
                wrap_line = int'(f_line);
            end
        end
        checks++;
        if (st_hi != 480) begin errors++; $display("FAIL line_start_width: got %0d expected 480", st_hi); end
        checks++;
        if (skew != 0) begin errors++; $display("FAIL de_start_skew: got %0d expected 0", skew); end
        checks++;
        if (hs_lo != 41) begin errors++; $display("FAIL hsync_width: got %0d expected 41", hs_lo); end
        checks++;
        if (hs_first != 482 || hs_last != 522) begin
            errors++;
            $display("FAIL hsync_position: got %0d..%0d expected 482..522", hs_first, hs_last);
        end
        checks++;
        if (wraps != 1 || wrap_k != 524 || wrap_line != 1) begin
            errors++;
            $display("FAIL line_wrap: got wraps=%0d k=%0d y=%0d expected 1 524 1", wraps, wrap_k, wrap_line);
        end
        checks++;
        if (fs_cnt != 0 || f_vga != 10'd1) begin
            errors++;
            $display("FAIL line_period: got fs=%0d x=%0d expected 0 1", fs_cnt, f_vga);
        end
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            step_full();
            if (f_vga == 10'd300) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reach_x300: got timeout expected x=300"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (f_vec !== IDLE_VEC) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", f_vec, IDLE_VEC);
        end
        en_full = 1'b0;
        #3 rst_n = 1'b1;
        model_reset();
        step_full();
        checks++;
        if (f_vec !== IDLE_VEC) begin
            errors++;
            $display("FAIL post_reset_idle: got %h expected %h", f_vec, IDLE_VEC);
        end
        en_full = 1'b1;
        step_full();
        checks++;
        if ({f_fs, f_st, f_vga, f_line} !== {2'b11, 10'd0, 9'd0}) begin
            errors++;
            $display("FAIL restart_frame: got fs=%b st=%b x=%0d y=%0d expected 1 1 0 0", f_fs, f_st, f_vga, f_line);
        end
        en_full = 1'b0;
    endtask

    task automatic test_frame();
        int fs_cnt = 0, fs_bad = 0, vs_lo = 0, vs_x = -1, vs_y = -1;
        step_small(1'b1);
        checks++;
        if ({s_fs, s_st, s_vga, s_line} !== {2'b11, 10'd0, 9'd0}) begin
            errors++;
            $display("FAIL small_first: got fs=%b st=%b x=%0d y=%0d expected 1 1 0 0", s_fs, s_st, s_vga, s_line);
        end
`ifdef LCD_FRAME_COUNT_EN
        checks++;
        if (s_fc !== 16'd1) begin errors++; $display("FAIL framecount_1: got %0d expected 1", s_fc); end
`endif
        for (int k = 1; k <= 3 * S_FT; k++) begin
            step_small(1'b1);
            if (s_fs) begin
                fs_cnt++;
                if (k % S_FT != 0) fs_bad++;
`ifdef LCD_FRAME_COUNT_EN
                checks++;
                if (s_fc !== 16'(fs_cnt + 1)) begin
                    errors++;
                    $display("FAIL framecount_step: got %0d expected %0d", s_fc, fs_cnt + 1);
                end
`endif
            end
            if (!s_vs) begin
                vs_lo++;
                if (vs_y < 0) begin
                    vs_y = int'(s_line);
                    vs_x = int'(s_vga);
                end
            end
        end
        checks++;
        if (fs_cnt != 3 || fs_bad != 0) begin
            errors++;
            $display("FAIL frame_period: got pulses=%0d off_period=%0d expected 3 0", fs_cnt, fs_bad);
        end
        checks++;
        if (vs_lo != 3 * S_VS * S_HT) begin
            errors++;
            $display("FAIL vsync_width: got %0d expected %0d", vs_lo, 3 * S_VS * S_HT);
        end
        checks++;
        if (vs_y != S_VA + S_VF || vs_x != 0) begin
            errors++;
            $display("FAIL vsync_start: got y=%0d x=%0d expected %0d 0", vs_y, vs_x, S_VA + S_VF);
        end
    endtask

    task automatic test_drain();
        logic found = 1'b0;
        int rem, fs_cnt = 0, bad = 0;
        for (int k = 0; k < 2 * S_FT && !found; k++) begin
            step_small(1'b1);
            if (s_line == 9'd4 && s_vga == 10'd0) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reach_line4: got timeout expected y=4"); end
        rem = S_FT - 4 * S_HT;
        for (int k = 1; k < rem; k++) begin
            step_small(1'b0);
            if (s_fs) fs_cnt++;
        end
        checks++;
        if ({s_vga, s_line} !== {10'(S_HT - 1), 9'(S_VT - 1)} || fs_cnt != 0) begin
            errors++;
            $display("FAIL drain_last: got x=%0d y=%0d fs=%0d expected %0d %0d 0", s_vga, s_line, fs_cnt, S_HT - 1, S_VT - 1);
        end
        step_small(1'b0);
        checks++;
        if (s_vec !== IDLE_VEC) begin
            errors++;
            $display("FAIL drain_idle: got %h expected %h", s_vec, IDLE_VEC);
        end
        for (int k = 0; k < 2 * S_FT; k++) begin
            step_small(1'b0);
            if (s_vec !== IDLE_VEC) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stays_idle: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_random();
        logic en = 1'b0;
        int run_left = 0;
        logic [23:0] exp_v;
        for (int k = 0; k < 4000; k++) begin
            if (run_left == 0) begin
                en       = 1'($urandom_range(0, 1));
                run_left = int'($urandom_range(1, 500));
            end
            run_left--;
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (s_vec !== IDLE_VEC) begin
                    errors++;
                    $display("FAIL rand_reset: got %h expected %h", s_vec, IDLE_VEC);
                end
                rst_n = 1'b1;
                model_reset();
            end
            step_small(en);
            exp_v = model_vec();
            checks++;
            if (s_vec !== exp_v) begin
                errors++;
                $display("FAIL rand_cycle %0d: got %h expected %h", k, s_vec, exp_v);
            end
`ifdef LCD_FRAME_COUNT_EN
            checks++;
            if (s_fc !== m_fc) begin
                errors++;
                $display("FAIL rand_framecount %0d: got %0d expected %0d", k, s_fc, m_fc);
            end
`endif
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en_full  = 1'b0;
        en_small = 1'b0;
        model_reset();
        test_reset();
        test_first_pixel();
        test_line();
        test_reset_mid();
        test_frame();
        test_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
